// File: rtl/psx_frame_sequencer_pkg.sv
// ============================================================================
// psx_frame_sequencer_pkg
// Shared state encoding, protocol constants and small helpers for the PSX
// frame sequencer.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package psx_frame_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_START = 3'd2,
      ST_XFER  = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERR   = 3'd5,
      ST_HOLD  = 3'd6
   } state_t;

   localparam logic [7:0] PSX_CMD_START     = 8'h01;
   localparam logic [7:0] PSX_CMD_POLL      = 8'h42;
   localparam logic [7:0] PSX_RESP_MARK     = 8'h5A;
   localparam logic [3:0] PSX_BYTES_DIGITAL = 4'd5;
   localparam logic [3:0] PSX_BYTES_MAX     = 4'd9;

   function automatic logic [7:0] tx_byte_of(input logic [3:0] idx);
      case (idx)
         4'd0:    return PSX_CMD_START;
         4'd1:    return PSX_CMD_POLL;
         default: return 8'h00;
      endcase
   endfunction

   // Frame length announced by the low ID nibble (half-words after the header).
   function automatic logic [3:0] analog_len(input logic [3:0] nib);
      logic [5:0] n;
      n = 6'd3 + {1'b0, nib, 1'b0};
      if (n < 6'd5) return PSX_BYTES_DIGITAL;
      if (n > 6'd9) return PSX_BYTES_MAX;
      return n[3:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/psx_byte_shifter.sv
// ============================================================================
// psx_byte_shifter
// c_clk edge detection, bit counting, TX bit select and LSB-first RX shifting.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module psx_byte_shifter (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       enable,
   input  logic       c_clk,
   input  logic       dat,
   input  logic [7:0] tx_byte,
   output logic       fall,
   output logic       tx_bit,
   output logic       byte_done,
   output logic [2:0] bit_idx,
   output logic [7:0] rx
);

   logic c_q;
   logic rise;

   assign fall   = c_q & ~c_clk & enable;
   assign rise   = ~c_q & c_clk & enable;
   assign tx_bit = tx_byte[bit_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         c_q       <= 1'b1;
         bit_idx   <= 3'd0;
         rx        <= 8'h00;
         byte_done <= 1'b0;
      end else begin
         c_q       <= c_clk;
         byte_done <= 1'b0;
         if (clear) begin
            bit_idx <= 3'd0;
            rx      <= 8'h00;
         end else if (rise) begin
            rx        <= {dat, rx[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            byte_done <= (bit_idx == 3'd7);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/psx_frame_sequencer.sv
// ============================================================================
// psx_frame_sequencer
// Frame-level PSX pad master: ATT/gen sequencing, byte assembly, publishing.
// Optional analog-stick support with macro PSX_ANALOG_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module psx_frame_sequencer #(
   parameter logic [19:0] POLL_PERIOD = 20'd800000,
   parameter logic [7:0]  ATT_SETUP   = 8'd200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        poll_en,
   input  logic        c_clk,
   input  logic        c_ready,
   input  logic        c_err,
   input  logic        psx_dat,
   output logic        gen,
   output logic [3:0]  bytes_expected,
   output logic        psx_att,
   output logic        psx_cmd,
   output logic [7:0]  id_byte,
   output logic [15:0] buttons,
   output logic        frame_valid,
   output logic        frame_err,
   output logic        busy,
   output logic [31:0] sticks
);

   import psx_frame_sequencer_pkg::*;

`ifdef PSX_ANALOG_EN
   localparam logic [3:0] BYTE_LIMIT = PSX_BYTES_MAX;
`else
   localparam logic [3:0] BYTE_LIMIT = 4'd8;
`endif

   state_t      state;
   logic [19:0] cnt;
   logic [3:0]  byte_idx;
   logic [7:0]  b1, b2, b3, b4;
   logic        fall, tx_bit, byte_done;
   logic [2:0]  bit_idx;
   logic [7:0]  rx;
   logic        frame_good;

   psx_byte_shifter u_shifter (
      .clk       (clk),
      .rst       (rst),
      .clear     (state == ST_SETUP),
      .enable    ((state == ST_XFER) && (byte_idx < BYTE_LIMIT)),
      .c_clk     (c_clk),
      .dat       (psx_dat),
      .tx_byte   (tx_byte_of(byte_idx)),
      .fall      (fall),
      .tx_bit    (tx_bit),
      .byte_done (byte_done),
      .bit_idx   (bit_idx),
      .rx        (rx)
   );

   assign frame_good = (b2 == PSX_RESP_MARK) && (byte_idx == bytes_expected) &&
                       (bit_idx == 3'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_idx <= 4'd0;
         b1 <= 8'h00;
         b2 <= 8'h00;
         b3 <= 8'h00;
         b4 <= 8'h00;
      end else if (state == ST_SETUP) begin
         byte_idx <= 4'd0;
      end else if (byte_done && (byte_idx < BYTE_LIMIT)) begin
         byte_idx <= byte_idx + 4'd1;
         case (byte_idx)
            4'd1:    b1 <= rx;
            4'd2:    b2 <= rx;
            4'd3:    b3 <= rx;
            4'd4:    b4 <= rx;
            default: ;
         endcase
      end
   end

`ifdef PSX_ANALOG_EN
   logic [7:0] b5, b6, b7, b8;
   logic [3:0] exp_q;

   assign bytes_expected = exp_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         exp_q  <= PSX_BYTES_DIGITAL;
         b5     <= 8'h00;
         b6     <= 8'h00;
         b7     <= 8'h00;
         b8     <= 8'h00;
         sticks <= 32'h0;
      end else begin
         if (state == ST_SETUP)
            exp_q <= PSX_BYTES_DIGITAL;
         else if (byte_done && (byte_idx == 4'd1))
            exp_q <= analog_len(rx[3:0]);
         if (byte_done && (state != ST_SETUP)) begin
            case (byte_idx)
               4'd5:    b5 <= rx;
               4'd6:    b6 <= rx;
               4'd7:    b7 <= rx;
               4'd8:    b8 <= rx;
               default: ;
            endcase
         end
         if ((state == ST_DONE) && frame_good)
            sticks <= {b8, b7, b6, b5};
      end
   end
`else
   assign bytes_expected = PSX_BYTES_DIGITAL;
   assign sticks         = 32'h0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= 20'd0;
         gen         <= 1'b0;
         psx_att     <= 1'b1;
         psx_cmd     <= 1'b1;
         id_byte     <= 8'h00;
         buttons     <= 16'h0000;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         gen         <= 1'b0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (poll_en) begin
                  state   <= ST_SETUP;
                  cnt     <= 20'd0;
                  psx_att <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            ST_SETUP: begin
               if (cnt == ({12'd0, ATT_SETUP} - 20'd1)) begin
                  state   <= ST_START;
                  gen     <= 1'b1;
                  psx_cmd <= PSX_CMD_START[0];
               end else begin
                  cnt <= cnt + 20'd1;
               end
            end
            ST_START: state <= ST_XFER;
            ST_XFER: begin
               // c_err wins when both arrive together.
               if (c_err)
                  state <= ST_ERR;
               else if (c_ready)
                  state <= ST_DONE;
               if (fall)
                  psx_cmd <= tx_bit;
            end
            ST_DONE: begin
               if (frame_good) begin
                  id_byte     <= b1;
                  buttons     <= ~{b4, b3};
                  frame_valid <= 1'b1;
               end else begin
                  frame_err <= 1'b1;
               end
               psx_att <= 1'b1;
               psx_cmd <= 1'b1;
               cnt     <= 20'd0;
               state   <= ST_HOLD;
            end
            ST_ERR: begin
               frame_err <= 1'b1;
               psx_att   <= 1'b1;
               psx_cmd   <= 1'b1;
               cnt       <= 20'd0;
               state     <= ST_HOLD;
            end
            ST_HOLD: begin
               if (cnt == (POLL_PERIOD - 20'd1)) begin
                  cnt <= 20'd0;
                  if (poll_en) begin
                     state   <= ST_SETUP;
                     psx_att <= 1'b0;
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 20'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_psx_frame_sequencer.sv
// ============================================================================
// tb_psx_frame_sequencer
// Directed bench with a pad model and a clock-generator model.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_psx_frame_sequencer;

   localparam int P = 20;
   localparam int S = 5;

   logic        clk = 1'b0;
   logic        rst, poll_en, c_clk, c_ready, c_err, psx_dat;
   logic        gen, psx_att, psx_cmd, frame_valid, frame_err, busy;
   logic [3:0]  bytes_expected;
   logic [7:0]  id_byte;
   logic [15:0] buttons;
   logic [31:0] sticks;

   int total = 0;
   int bad   = 0;
   int fv_cnt = 0, fe_cnt = 0, gen_cnt = 0;

   logic [7:0] pad_q [9];
   logic [7:0] cmd_q [9];
   logic [7:0] exp_cmd [5];

   psx_frame_sequencer #(
      .POLL_PERIOD (20'd20),
      .ATT_SETUP   (8'd5)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .poll_en        (poll_en),
      .c_clk          (c_clk),
      .c_ready        (c_ready),
      .c_err          (c_err),
      .psx_dat        (psx_dat),
      .gen            (gen),
      .bytes_expected (bytes_expected),
      .psx_att        (psx_att),
      .psx_cmd        (psx_cmd),
      .id_byte        (id_byte),
      .buttons        (buttons),
      .frame_valid    (frame_valid),
      .frame_err      (frame_err),
      .busy           (busy),
      .sticks         (sticks)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      fv_cnt  <= fv_cnt + int'(frame_valid);
      fe_cnt  <= fe_cnt + int'(frame_err);
      gen_cnt <= gen_cnt + int'(gen);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_gen(input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         seen = gen;
      end
      chk(tag, seen, 1'b1);
   endtask

   // Clock-generator + pad model: pad drives DAT on c_clk fall, samples CMD before the rise.
   task automatic send_byte(input logic [7:0] pad, input int nbits, output logic [7:0] seen);
      seen = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         c_clk   = 1'b0;
         psx_dat = pad[i];
         repeat (3) @(negedge clk);
         seen[i] = psx_cmd;
         c_clk   = 1'b1;
         repeat (3) @(negedge clk);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic send_frame(input int first, input int last);
      logic [7:0] s;
      for (int k = first; k <= last; k++) begin
         send_byte(pad_q[k], 8, s);
         cmd_q[k] = s;
      end
   endtask

   task automatic end_frame();
      c_ready = 1'b1;
      @(negedge clk);
      c_ready = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int fv0, fe0, gen0, n, fe_at, gen_at;
      logic [7:0] s;

      rst = 1'b1; poll_en = 1'b0; c_clk = 1'b1; psx_dat = 1'b1;
      c_ready = 1'b0; c_err = 1'b0;
      exp_cmd = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
      repeat (3) @(negedge clk);

      chk("rst_gen", gen, 1'b0);
      chk("rst_att", psx_att, 1'b1);
      chk("rst_cmd", psx_cmd, 1'b1);
      chk("rst_id", id_byte, 8'h00);
      chk("rst_buttons", buttons, 16'h0000);
      chk("rst_fv", frame_valid, 1'b0);
      chk("rst_fe", frame_err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_bexp", bytes_expected, 4'd5);
      chk("rst_sticks", sticks, 32'h0);

      // 1: good digital frame
      rst = 1'b0; poll_en = 1'b1;
      wait_gen("t1_gen");
      chk("t1_att_low", psx_att, 1'b0);
      chk("t1_busy", busy, 1'b1);
      pad_q = '{8'hFF, 8'h41, 8'h5A, 8'hFE, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00};
      send_frame(0, 4);
      for (int k = 0; k < 5; k++) chk($sformatf("t1_cmd%0d", k), cmd_q[k], exp_cmd[k]);
      fv0 = fv_cnt;
      end_frame();
      chk("t1_fv", frame_valid, 1'b1);
      chk("t1_id", id_byte, 8'h41);
      chk("t1_buttons", buttons, 16'h8001);
      chk("t1_att_high", psx_att, 1'b1);
      chk("t1_cmd_idle", psx_cmd, 1'b1);
      repeat (2) @(negedge clk);
      chk("t1_fv_once", fv_cnt - fv0, 1);

      // 2: bad response marker
      wait_gen("t2_gen");
      pad_q = '{8'hFF, 8'h41, 8'h00, 8'hFE, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00};
      send_frame(0, 4);
      end_frame();
      chk("t2_fe", frame_err, 1'b1);
      chk("t2_fv", frame_valid, 1'b0);
      chk("t2_id_kept", id_byte, 8'h41);
      chk("t2_buttons_kept", buttons, 16'h8001);
      chk("t2_att_high", psx_att, 1'b1);

      // 3: c_err together with c_ready after byte 2
      wait_gen("t3_gen");
      pad_q = '{8'hFF, 8'h41, 8'h5A, 8'hFE, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00};
      send_frame(0, 2);
      fv0 = fv_cnt;
      c_err = 1'b1; c_ready = 1'b1;
      n = 0; fe_at = 0; gen_at = 0;
      while (n < 300 && gen_at == 0) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1) begin
            c_err = 1'b0; c_ready = 1'b0;
         end
         if (frame_err && fe_at == 0) fe_at = n;
         if (gen) gen_at = n;
      end
      chk("t3_fe_at", fe_at, 2);
      // gen_at counts from the edge that sampled c_err (n=1).
      chk("t3_restart", gen_at - 1, P + S + 1);
      chk("t3_no_fv", fv_cnt - fv0, 0);

      // 4: reset in the middle of byte 3, then a fresh frame
      @(negedge clk);
      send_frame(0, 2);
      send_byte(8'hFE, 4, s);
      rst = 1'b1; c_clk = 1'b1;
      @(negedge clk);
      chk("t4_att", psx_att, 1'b1);
      chk("t4_gen", gen, 1'b0);
      chk("t4_busy", busy, 1'b0);
      chk("t4_id_cleared", id_byte, 8'h00);
      rst = 1'b0;
      wait_gen("t4_gen2");
      pad_q = '{8'hFF, 8'h41, 8'h5A, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
      send_frame(0, 4);
      end_frame();
      chk("t4_fv", frame_valid, 1'b1);
      chk("t4_id", id_byte, 8'h41);
      chk("t4_buttons", buttons, 16'h00FF);

      // 5: poll_en dropped during XFER
      wait_gen("t5_gen");
      pad_q = '{8'hFF, 8'h41, 8'h5A, 8'hFE, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00};
      send_frame(0, 1);
      poll_en = 1'b0;
      send_frame(2, 4);
      end_frame();
      chk("t5_fv", frame_valid, 1'b1);
      chk("t5_buttons", buttons, 16'h8001);
      gen0 = gen_cnt;
      repeat (P + S + 10) @(negedge clk);
      chk("t5_idle_busy", busy, 1'b0);
      chk("t5_idle_att", psx_att, 1'b1);
      chk("t5_no_gen", gen_cnt - gen0, 0);

`ifdef PSX_ANALOG_EN
      // 6: analog frame with ID 0x73
      poll_en = 1'b1;
      wait_gen("t6_gen");
      pad_q = '{8'hFF, 8'h73, 8'h5A, 8'hFE, 8'h7F, 8'h11, 8'h22, 8'h33, 8'h44};
      send_frame(0, 1);
      chk("t6_bexp", bytes_expected, 4'd9);
      send_frame(2, 8);
      end_frame();
      chk("t6_fv", frame_valid, 1'b1);
      chk("t6_id", id_byte, 8'h73);
      chk("t6_sticks", sticks, 32'h44332211);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
